// File: rtl/rubik_drc_pkg.sv
// Shared constants and types for the RUBIK read-response queue splitter.
// Defines the half width, the half-valid mask encodings and the field
// offsets of one {mask, hi, lo} response beat.
package rubik_drc_pkg;

  // Width of one response half, and of each output queue payload.
  localparam int HALF_W = 256;

  // Response beat layout: {mask[1:0], hi[HALF_W-1:0], lo[HALF_W-1:0]}.
  localparam int LO_LSB   = 0;
  localparam int HI_LSB   = HALF_W;
  localparam int MASK_LSB = 2 * HALF_W;
  localparam int BEAT_W   = 2 * HALF_W + 2;

  // Half-valid mask: bit 0 marks the lo half, bit 1 marks the hi half.
  typedef enum logic [1:0] {
    MASK_NONE = 2'b00,
    MASK_LO   = 2'b01,
    MASK_HI   = 2'b10,
    MASK_BOTH = 2'b11
  } mask_e;

  // Offsets for a beat built from halves of width w, so a top level that
  // overrides its half width still slices the beat consistently.
  function automatic int hi_lsb(input int w);
    return w;
  endfunction

  function automatic int mask_lsb(input int w);
    return 2 * w;
  endfunction

endpackage : rubik_drc_pkg

// File: rtl/rubik_drc_qsplit_if.sv
// Handshake bundle around the queue splitter: the incoming response beat
// stream from the data FIFO pair, and the two outgoing half queues.
interface rubik_drc_qsplit_if #(
  parameter int HALF_W = rubik_drc_pkg::HALF_W
);

  logic                  data_fifo_vld;
  logic                  data_fifo_rdy;
  logic [2*HALF_W+1:0]   data_fifo_pd;

  logic                  dr2drc_q0_vld;
  logic [HALF_W-1:0]     dr2drc_q0_pd;
  logic                  dr2drc_q0_rdy;

  logic                  dr2drc_q1_vld;
  logic [HALF_W-1:0]     dr2drc_q1_pd;
  logic                  dr2drc_q1_rdy;

  // Producer of beats and consumer of both queues.
  modport master (
    output data_fifo_vld, data_fifo_pd, dr2drc_q0_rdy, dr2drc_q1_rdy,
    input  data_fifo_rdy, dr2drc_q0_vld, dr2drc_q0_pd,
           dr2drc_q1_vld, dr2drc_q1_pd
  );

  // The splitter itself.
  modport slave (
    input  data_fifo_vld, data_fifo_pd, dr2drc_q0_rdy, dr2drc_q1_rdy,
    output data_fifo_rdy, dr2drc_q0_vld, dr2drc_q0_pd,
           dr2drc_q1_vld, dr2drc_q1_pd
  );

endinterface : rubik_drc_qsplit_if

// File: rtl/rubik_drc_qbuf2.sv
// Two-entry valid/ready FIFO holding one output queue of halves.
// The head is read straight from storage, so vld/pd only change on a clock
// edge and stay stable while the consumer holds rdy low.
module rubik_drc_qbuf2 #(
  parameter int W     = 256,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_pd,
  output logic [1:0]   cnt,
  output logic         out_vld,
  output logic [W-1:0] out_pd,
  input  logic         out_rdy
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;
  logic         push_ok;

  assign out_vld = (cnt != 2'd0);
  assign out_pd  = mem[rd_ptr];
  assign pop     = out_vld & out_rdy;
  // The top never pushes into a full queue; the guard keeps a stray push
  // from overwriting the head.
  assign push_ok = push & (cnt != FULL_CNT);

  // Storage, pointers and occupancy; push and pop may share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset too, so the head payload reads 0 (not X) from
      // reset; that buys a defined pd at the price of reset on the data flops.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked logic, so every
      // read in this block sees the pre-edge value regardless of order.
      if (push_ok) begin
        mem[wr_ptr] <= push_pd;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule : rubik_drc_qbuf2

// File: rtl/rubik_drc_qsplit.sv
// RUBIK read-response queue splitter. Packs the valid 256-bit halves of each
// response beat into two dense queues, dealing halves alternately between
// q0 and q1 from a toggling fill pointer.
module rubik_drc_qsplit
  import rubik_drc_pkg::*;
#(
  parameter int HALF_W = rubik_drc_pkg::HALF_W,
  parameter int QDEPTH = 2
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  rubik_drc_qsplit_if.slave  bus,
  output logic               fill_half
);

  localparam int         HI_OFF   = hi_lsb(HALF_W);
  localparam int         MASK_OFF = mask_lsb(HALF_W);
  localparam logic [1:0] QFULL    = 2'(QDEPTH);

  logic [HALF_W-1:0] lo;
  logic [HALF_W-1:0] hi;
  mask_e             mask;
  logic              rdy;
  logic              accept;
  logic              fp;
  logic              push0;
  logic              push1;
  logic [HALF_W-1:0] pd0;
  logic [HALF_W-1:0] pd1;
  logic [1:0]        cnt0;
  logic [1:0]        cnt1;

  assign lo   = bus.data_fifo_pd[0 +: HALF_W];
  assign hi   = bus.data_fifo_pd[HI_OFF +: HALF_W];
  assign mask = mask_e'(bus.data_fifo_pd[MASK_OFF +: 2]);

  // Ready depends only on registered occupancy (plus reset), never on the
  // beat itself. Either queue full blocks input even when the pending mask
  // would not touch it; this keeps the ready path short.
  assign rdy               = ~nvdla_core_rst & (cnt0 != QFULL) & (cnt1 != QFULL);
  assign bus.data_fifo_rdy = rdy;
  assign accept            = bus.data_fifo_vld & rdy;
  assign fill_half         = fp;

  // Steer the valid halves of an accepted beat into the queues.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    push0 = 1'b0;
    push1 = 1'b0;
    pd0   = lo;
    pd1   = lo;
    if (accept) begin
      case (mask)
        MASK_BOTH: begin
          push0 = 1'b1;
          push1 = 1'b1;
          pd0   = fp ? hi : lo;
          pd1   = fp ? lo : hi;
        end
        MASK_LO: begin
          push0 = ~fp;
          push1 = fp;
        end
        MASK_HI: begin
          push0 = ~fp;
          push1 = fp;
          pd0   = hi;
          pd1   = hi;
        end
        default: begin
          push0 = 1'b0;
          push1 = 1'b0;
        end
      endcase
    end
  end

  // Fill pointer: a single half lands at q[fp] and moves the pointer on;
  // a full beat fills both queues and leaves it where it was.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      fp <= 1'b0;
    end else if (accept && (mask == MASK_LO || mask == MASK_HI)) begin
      fp <= ~fp;
    end
  end

  rubik_drc_qbuf2 #(
    .W     (HALF_W),
    .DEPTH (QDEPTH)
  ) u_q0 (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (push0),
    .push_pd (pd0),
    .cnt     (cnt0),
    .out_vld (bus.dr2drc_q0_vld),
    .out_pd  (bus.dr2drc_q0_pd),
    .out_rdy (bus.dr2drc_q0_rdy)
  );

  rubik_drc_qbuf2 #(
    .W     (HALF_W),
    .DEPTH (QDEPTH)
  ) u_q1 (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (push1),
    .push_pd (pd1),
    .cnt     (cnt1),
    .out_vld (bus.dr2drc_q1_vld),
    .out_pd  (bus.dr2drc_q1_pd),
    .out_rdy (bus.dr2drc_q1_rdy)
  );

endmodule : rubik_drc_qsplit

// File: tb/tb_rubik_drc_qsplit.sv
// Self-checking bench for rubik_drc_qsplit: a directed vector table, a
// hand-written mid-operation reset sequence, and a randomized run compared
// against a queue-based reference model.
module tb_rubik_drc_qsplit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill_half;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rubik_drc_qsplit_if bus ();

  rubik_drc_qsplit dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus),
    .fill_half      (fill_half)
  );

  typedef struct {
    bit           vld;
    logic [1:0]   mask;
    logic [255:0] lo;
    logic [255:0] hi;
    bit           r0;
    bit           r1;
    bit           e_rdy;
    bit           e_v0;
    logic [255:0] e_p0;
    bit           e_v1;
    logic [255:0] e_p1;
    bit           e_fh;
  } vec_t;

  vec_t tbl [16];

  // Reference model state: two queues of halves and the fill pointer.
  logic [255:0] mq0 [$];
  logic [255:0] mq1 [$];
  bit           mfp;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] half(input int n);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'hC0DE0000 + 32'(n) + 32'(i << 8);
    return r;
  endfunction

  function automatic logic [255:0] rnd_half();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mkv(input bit vld, input logic [1:0] mask,
                               input logic [255:0] lo, input logic [255:0] hi,
                               input bit r0, input bit r1, input bit e_rdy,
                               input bit e_v0, input logic [255:0] e_p0,
                               input bit e_v1, input logic [255:0] e_p1,
                               input bit e_fh);
    vec_t v;
    v.vld = vld; v.mask = mask; v.lo = lo; v.hi = hi; v.r0 = r0; v.r1 = r1;
    v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_p0 = e_p0;
    v.e_v1 = e_v1; v.e_p1 = e_p1; v.e_fh = e_fh;
    return v;
  endfunction

  task automatic drive(input bit vld, input logic [1:0] mask, input logic [255:0] lo,
                       input logic [255:0] hi, input bit r0, input bit r1);
    bus.data_fifo_vld = vld;
    bus.data_fifo_pd  = {mask, hi, lo};
    bus.dr2drc_q0_rdy = r0;
    bus.dr2drc_q1_rdy = r1;
  endtask

  // One clock of the reference model, using the inputs held before the edge.
  // Valid halves (lo first, then hi) are dealt to q[fp] one at a time, the
  // pointer flipping after each; ready is both queues below two entries.
  task automatic model_step();
    bit           m_rdy;
    logic [1:0]   m;
    logic [255:0] lo_h, hi_h;
    m_rdy = !rst && mq0.size() < 2 && mq1.size() < 2;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      mfp = 1'b0;
    end else begin
      if (mq0.size() > 0 && bus.dr2drc_q0_rdy) void'(mq0.pop_front());
      if (mq1.size() > 0 && bus.dr2drc_q1_rdy) void'(mq1.pop_front());
      if (bus.data_fifo_vld && m_rdy) begin
        m    = bus.data_fifo_pd[513:512];
        lo_h = bus.data_fifo_pd[255:0];
        hi_h = bus.data_fifo_pd[511:256];
        if (m[0]) begin
          if (mfp) mq1.push_back(lo_h); else mq0.push_back(lo_h);
          mfp = ~mfp;
        end
        if (m[1]) begin
          if (mfp) mq1.push_back(hi_h); else mq0.push_back(hi_h);
          mfp = ~mfp;
        end
      end
    end
  endtask

  task automatic compare_model(input int cyc);
    bit e_rdy;
    e_rdy = !rst && mq0.size() < 2 && mq1.size() < 2;
    check($sformatf("rnd%0d rdy", cyc), 256'(bus.data_fifo_rdy), 256'(e_rdy));
    check($sformatf("rnd%0d q0_vld", cyc), 256'(bus.dr2drc_q0_vld), 256'(mq0.size() > 0));
    check($sformatf("rnd%0d q1_vld", cyc), 256'(bus.dr2drc_q1_vld), 256'(mq1.size() > 0));
    check($sformatf("rnd%0d fill_half", cyc), 256'(fill_half), 256'(mfp));
    if (mq0.size() > 0) check($sformatf("rnd%0d q0_pd", cyc), bus.dr2drc_q0_pd, mq0[0]);
    if (mq1.size() > 0) check($sformatf("rnd%0d q1_pd", cyc), bus.dr2drc_q1_pd, mq1[0]);
  endtask

  initial begin
    logic [255:0] ha, hb, hc, hd, he, hf, hg, hh, hz, z;
    ha = half(1); hb = half(2); hc = half(3); hd = half(4);
    he = half(5); hf = half(6); hg = half(7); hh = half(8);
    hz = half(99); z = '0;

    //          vld mask   lo  hi  r0 r1 | rdy v0 p0  v1 p1  fh
    tbl[0]  = mkv(1, 2'b11, ha, hb, 1, 1,  1,  1, ha, 1, hb, 0);
    tbl[1]  = mkv(0, 2'b00, hz, hz, 1, 1,  1,  0, z,  0, z,  0);
    tbl[2]  = mkv(1, 2'b01, ha, hz, 1, 1,  1,  1, ha, 0, z,  1);
    tbl[3]  = mkv(1, 2'b10, hz, hb, 1, 1,  1,  0, z,  1, hb, 0);
    tbl[4]  = mkv(1, 2'b01, hc, hz, 1, 1,  1,  1, hc, 0, z,  1);
    tbl[5]  = mkv(1, 2'b11, hd, he, 1, 1,  1,  1, he, 1, hd, 1);
    tbl[6]  = mkv(1, 2'b00, hf, hg, 1, 1,  1,  0, z,  0, z,  1);
    tbl[7]  = mkv(1, 2'b10, hz, hh, 1, 1,  1,  0, z,  1, hh, 0);
    tbl[8]  = mkv(0, 2'b00, hz, hz, 1, 1,  1,  0, z,  0, z,  0);
    tbl[9]  = mkv(1, 2'b11, ha, hb, 0, 1,  1,  1, ha, 1, hb, 0);
    tbl[10] = mkv(1, 2'b11, hc, hd, 0, 1,  0,  1, ha, 1, hd, 0);
    tbl[11] = mkv(1, 2'b11, he, hf, 0, 1,  0,  1, ha, 0, z,  0);
    tbl[12] = mkv(1, 2'b11, he, hf, 0, 1,  0,  1, ha, 0, z,  0);
    tbl[13] = mkv(1, 2'b11, he, hf, 1, 1,  1,  1, hc, 0, z,  0);
    tbl[14] = mkv(1, 2'b11, he, hf, 1, 1,  1,  1, he, 1, hf, 0);
    tbl[15] = mkv(0, 2'b00, hz, hz, 1, 1,  1,  0, z,  0, z,  0);

    drive(0, 2'b00, z, z, 1, 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // State in the first cycle after reset deasserts.
    #1;
    check("reset rdy", 256'(bus.data_fifo_rdy), 256'(1));
    check("reset q0_vld", 256'(bus.dr2drc_q0_vld), 256'(0));
    check("reset q1_vld", 256'(bus.dr2drc_q1_vld), 256'(0));
    check("reset q0_pd", bus.dr2drc_q0_pd, z);
    check("reset q1_pd", bus.dr2drc_q1_pd, z);
    check("reset fill_half", 256'(fill_half), 256'(0));

    // Directed vector table: each row is driven for one cycle and the state
    // after the following edge is compared.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].vld, tbl[i].mask, tbl[i].lo, tbl[i].hi, tbl[i].r0, tbl[i].r1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rdy", i), 256'(bus.data_fifo_rdy), 256'(tbl[i].e_rdy));
      check($sformatf("vec%0d q0_vld", i), 256'(bus.dr2drc_q0_vld), 256'(tbl[i].e_v0));
      check($sformatf("vec%0d q1_vld", i), 256'(bus.dr2drc_q1_vld), 256'(tbl[i].e_v1));
      check($sformatf("vec%0d fill_half", i), 256'(fill_half), 256'(tbl[i].e_fh));
      if (tbl[i].e_v0) check($sformatf("vec%0d q0_pd", i), bus.dr2drc_q0_pd, tbl[i].e_p0);
      if (tbl[i].e_v1) check($sformatf("vec%0d q1_pd", i), bus.dr2drc_q1_pd, tbl[i].e_p1);
    end

    // Reset mid-operation with both queues holding data.
    drive(1, 2'b11, ha, hb, 0, 0);
    @(posedge clk); #1;
    check("mrst fill q0_pd", bus.dr2drc_q0_pd, ha);
    check("mrst fill q1_pd", bus.dr2drc_q1_pd, hb);
    drive(1, 2'b01, hc, hz, 0, 0);
    @(posedge clk); #1;
    check("mrst full rdy", 256'(bus.data_fifo_rdy), 256'(0));
    check("mrst full fill_half", 256'(fill_half), 256'(1));
    rst = 1'b1;
    drive(1, 2'b11, hd, he, 0, 0);
    #1;
    check("mrst rdy during reset", 256'(bus.data_fifo_rdy), 256'(0));
    @(posedge clk); #1;
    check("mrst q0_vld", 256'(bus.dr2drc_q0_vld), 256'(0));
    check("mrst q1_vld", 256'(bus.dr2drc_q1_vld), 256'(0));
    check("mrst fill_half", 256'(fill_half), 256'(0));
    rst = 1'b0;
    drive(1, 2'b01, hg, hz, 1, 1);
    #1;
    check("mrst rdy after deassert", 256'(bus.data_fifo_rdy), 256'(1));
    @(posedge clk); #1;
    check("mrst post q0_vld", 256'(bus.dr2drc_q0_vld), 256'(1));
    check("mrst post q0_pd", bus.dr2drc_q0_pd, hg);
    check("mrst post q1_vld", 256'(bus.dr2drc_q1_vld), 256'(0));
    check("mrst post fill_half", 256'(fill_half), 256'(1));

    // Randomized run against the reference model, starting from a reset so
    // the model and the design share a known state.
    rst = 1'b1;
    drive(0, 2'b00, z, z, 1, 1);
    @(posedge clk); model_step(); #1;
    compare_model(-1);
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd_half(), rnd_half(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      @(posedge clk); model_step(); #1;
      compare_model(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rubik_drc_qsplit

// File: doc/rubik_drc_qsplit.md
# rubik_drc_qsplit

Downstream consumer of the RUBIK read-response data FIFO pair. Takes each 512-bit response beat plus its 2-bit half-valid mask and packs only the valid 256-bit halves into two 256-bit queues (q0, q1) using a toggling fill-half pointer. Queues therefore stay dense even when responses carry a single half. Sits between the dr2drc data FIFOs and the RUBIK data-reorder core (drc).

## Interface
Parameters:
- HALF_W, 256, width of one half and of each queue payload.
- QDEPTH, 2, entries per output queue buffer. Fixed at 2; other values unsupported.

Ports:
- nvdla_core_clk  in  1  sole clock, all state on rising edge.
- nvdla_core_rst  in  1  synchronous, active-high reset.
- data_fifo_vld  in  1  input beat valid.
- data_fifo_rdy  out  1  input beat accepted when vld&rdy.
- data_fifo_pd  in  514  {mask[1:0], hi[255:0], lo[255:0]}.
- dr2drc_q0_vld  out  1  q0 head valid.
- dr2drc_q0_pd  out  256  q0 head data.
- dr2drc_q0_rdy  in  1  q0 pop.
- dr2drc_q1_vld / dr2drc_q1_pd / dr2drc_q1_rdy: same for q1.
- fill_half  out  1  current fill pointer (0: next single half goes to q0).

## Operation
- Input accept: data_fifo_rdy = (q0 cnt < 2) & (q1 cnt < 2). Registered-state only; no combinational path from data_fifo_pd, data_fifo_vld or dr2drc_q*_rdy to data_fifo_rdy.
- On accept, with fp = fill_half:
  - mask 11: lo → q[fp], hi → q[~fp]; fp unchanged.
  - mask 01: lo → q[fp]; fp toggles.
  - mask 10: hi → q[fp]; fp toggles.
  - mask 00: beat consumed, nothing written, fp unchanged.
- Each queue is a 2-entry FIFO. Push and pop in the same cycle are both honoured, with count unchanged.
- Order within a queue is strict arrival order.
- Reset: fill_half=0, both counts=0, dr2drc_q0_vld=dr2drc_q1_vld=0, data_fifo_rdy=1 in the first cycle after reset deasserts. dr2drc_q*_pd are don't-care while vld=0; the RTL drives 0 from reset.

## Timing
- Latency: a beat accepted in cycle N appears at the queue head (vld=1) in N+1 if that queue was empty.
- Throughput: one beat per cycle sustained while both consumers pop every cycle. Steady-state count ≤1, so ready never drops.
- Output hold: once dr2drc_q*_vld=1, vld and pd hold stable until rdy is seen high.
- Full: any queue at count 2 deasserts data_fifo_rdy in the next cycle. This holds even if that queue is not needed by the pending beat's mask, which is intentionally conservative.
- Simultaneous push/pop at count 2 cannot occur, because rdy was already low.
- Reset mid-operation: all buffered halves are discarded. The upstream handshake in the reset cycle is ignored; no accept occurs while nvdla_core_rst=1 (data_fifo_rdy forced 0 during reset).

## Structure
- Package rubik_drc_pkg: HALF_W, mask encodings (MASK_NONE=2'b00, MASK_LO=2'b01, MASK_HI=2'b10, MASK_BOTH=2'b11), and the 514-bit beat field offsets.
- Sub-module rubik_drc_qbuf2 holds the 2-entry valid/ready FIFO: push, push_pd, cnt, out vld/pd/rdy. It is instantiated twice (q0, q1). The top level holds fp, steering muxes and accept logic.

## Test plan
- Reset, then beat mask 11, lo=A, hi=B, consumers always ready → q0=A, q1=B in the cycle after accept; fill_half stays 0.
- Beats mask 01 lo=A, 10 hi=B, 01 lo=C → q0 gets A then C, q1 gets B; fill_half sequence 1,0,1.
- fill_half=1 then mask 11 lo=A, hi=B → q1=A, q0=B; fill_half stays 1.
- Mask 00 beat → accepted in one cycle, no q vld, fill_half unchanged.
- Hold dr2drc_q0_rdy=0 and stream mask 11 beats → q0 reaches count 2, data_fifo_rdy=0 next cycle, q0_pd stable. Release rdy → data_fifo_rdy returns 1 the following cycle, with no loss or reorder.
- Assert nvdla_core_rst with both queues holding data → next cycle both vld=0, fill_half=0. First post-reset beat mask 01 → q0.
